ram_pipe: RTL and testbench
===========================

RAM_PIPE -- requirements
Module: ram_pipe

Interface
REQ-001 Parameter DATA_W, default 32, data width in bits; SHALL be a multiple of 8 and ≥ 8.
REQ-002 Parameter DEPTH, default 4096, number of words; SHALL be a power of 2.
REQ-003 Parameter ADDR_W, default 32, byte-address width.
REQ-004 Parameter BASE_ADDR, default 0, byte address of word 0; SHALL be aligned to DEPTH*DATA_W/8.
REQ-005 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1, reset; synchronous, active-high.
REQ-007 Port req, input, 1, request valid.
REQ-008 Port gnt, output, 1, request accepted this cycle when req && gnt.
REQ-009 Port addr, input, ADDR_W, byte address.
REQ-010 Port we, input, 1, 1 = write, 0 = read.
REQ-011 Port be, input, DATA_W/8, byte enables, active-high, bit i covers wdata[8i+7:8i].
REQ-012 Port wdata, input, DATA_W, write data.
REQ-013 Port rvalid, output, 1, response valid.
REQ-014 Port rready, input, 1, response consumed when rvalid && rready.
REQ-015 Port rdata, output, DATA_W, read data; 0 for write responses and error responses.
REQ-016 Port err, output, 1, response error flag, qualified by rvalid.

Function
REQ-017 Word index = (addr - BASE_ADDR) >> log2(DATA_W/8); low log2(DATA_W/8) address bits SHALL be ignored.
REQ-018 Address out of range (addr < BASE_ADDR or addr ≥ BASE_ADDR + DEPTH*DATA_W/8) SHALL produce a response with err=1 and rdata=0, with no array access.
REQ-019 Accepted in-range write SHALL update only bytes with be[i]=1; be=0 SHALL leave the array unchanged and return err=0.
REQ-020 Reads SHALL ignore be and return the full word.
REQ-021 Every accepted request (read, write, error) SHALL produce exactly one response, in acceptance order.
REQ-022 The array SHALL be a synchronous single-port memory with one read/write access per cycle.
REQ-023 Response for a request accepted in cycle N SHALL appear no earlier than cycle N+1; with no older responses pending, rvalid SHALL be 1 in cycle N+1.
REQ-024 A 2-entry response buffer SHALL hold responses while rready=0; rvalid, rdata and err SHALL stay stable until consumed.
REQ-025 Occupancy = buffered responses + in-flight (accepted last cycle) response.
REQ-026 gnt = !rst && (occupancy < 2 || (rvalid && rready)); no response SHALL ever be dropped.
REQ-027 With rready held at 1, back-to-back requests SHALL be granted every cycle (throughput 1/cycle).
REQ-028 A read of address A in cycle N+1 after a write to A in cycle N SHALL return the newly written bytes.
REQ-029 gnt SHALL NOT depend combinationally on req.

Reset
REQ-030 While rst=1: gnt=0, rvalid=0, err=0, rdata=0; the response buffer and the in-flight flag SHALL be cleared.
REQ-031 A request in flight or buffered at reset SHALL be discarded without a response; a write accepted before reset asserts SHALL still have updated the array.
REQ-032 Array contents SHALL NOT be reset.

Verification
REQ-033 Write 0xDEADBEEF to 0x10 with be=4'hF, then read 0x10 with rready=1 -> read rvalid in the cycle after its grant, rdata=0xDEADBEEF, err=0.
REQ-034 Write 0x11223344 to 0x20 with be=4'b0101 over prior 0xFFFFFFFF -> read returns 0xFF22FF44.
REQ-035 Read at BASE_ADDR + DEPTH*4 -> err=1, rdata=0; array unchanged.
REQ-036 rready=0 with 4 requests issued -> exactly 2 granted and gnt=0 afterwards; raise rready -> 2 responses delivered in order, stable while stalled; remaining requests then granted.
REQ-037 rready=1 with 8 back-to-back reads -> gnt=1 every cycle and 8 consecutive rvalid cycles.
REQ-038 Assert rst for one cycle with 2 responses buffered -> rvalid=0 in the following cycle and no stale responses later.

Source files
------------

// File: rtl/ram_pipe_if.sv
// -----------------------------------------------------------------------------
// ram_pipe_if
// Request/response bus for the ram_pipe single-port memory.
//
// Request channel (master -> slave, accepted when req && gnt):
//   req    : request valid
//   gnt    : slave can take a request this cycle
//   addr   : byte address
//   we     : 1 = write, 0 = read
//   be     : byte enables (bit i covers wdata[8i+7:8i]), ignored on reads
//   wdata  : write data
// Response channel (slave -> master, consumed when rvalid && rready):
//   rvalid : response valid
//   rready : master consumes the response
//   rdata  : read data, zero for write and error responses
//   err    : address was out of range
// -----------------------------------------------------------------------------
interface ram_pipe_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  req;
    logic                  gnt;
    logic [ADDR_W-1:0]     addr;
    logic                  we;
    logic [DATA_W/8-1:0]   be;
    logic [DATA_W-1:0]     wdata;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_W-1:0]     rdata;
    logic                  err;

    modport master (
        output req, addr, we, be, wdata, rready,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, addr, we, be, wdata, rready,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/ram_pipe.sv
// -----------------------------------------------------------------------------
// ram_pipe
// Pipelined single-port synchronous RAM behind a req/gnt request channel and
// an rvalid/rready response channel.
//
// Each accepted request performs at most one array access at the acceptance
// edge and produces exactly one response, in acceptance order. The response
// of a request accepted in cycle N is held in an "in-flight" register during
// cycle N+1; if it cannot be consumed it moves into a 2-entry response
// buffer. Total occupancy (buffer + in-flight) never exceeds 2, which is
// enforced by gnt.
//
// Ports:
//   clk : clock, all state updates on its rising edge
//   rst : synchronous active-high reset (array contents are kept)
//   bus : ram_pipe_if.slave, request and response channels
//
// Parameters:
//   DATA_W    : data width, multiple of 8
//   DEPTH     : number of words, power of 2, at least 2
//   ADDR_W    : byte-address width
//   BASE_ADDR : byte address of word 0, aligned to the array size in bytes
// -----------------------------------------------------------------------------
module ram_pipe #(
    parameter int                 DATA_W    = 32,
    parameter int                 DEPTH     = 4096,
    parameter int                 ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
    input  logic        clk,
    input  logic        rst,
    ram_pipe_if.slave   bus
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam int IDX_W = $clog2(DEPTH);
    // Size of the mapped window in bytes, one bit wider than the address so
    // that windows ending at the top of the address space still compare.
    localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(DEPTH) * (ADDR_W+1)'(BYTES);

    // An offset is in range when the subtraction did not borrow and it falls
    // inside the window.
    function automatic logic f_in_range(input logic [ADDR_W:0] off);
        return (!off[ADDR_W]) && (off < SPAN);
    endfunction

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0]  r_mem [DEPTH];

    // Response buffer: slot 0 is always the oldest buffered response
    logic [DATA_W-1:0]  r_buf_data [2];
    logic               r_buf_err  [2];
    logic [1:0]         r_cnt;

    // Response of the request accepted on the previous edge
    logic               r_inf_vld;
    logic               r_inf_err;
    logic [DATA_W-1:0]  r_inf_data;

    // -------------------------------------------------------------------------
    // Combinational signals
    // -------------------------------------------------------------------------
    logic [ADDR_W:0]    w_off_ext;
    logic               w_in_range;
    logic [IDX_W-1:0]   w_idx;
    logic               w_gnt;
    logic               w_acc;
    logic               w_pop;
    logic [1:0]         w_occ;
    logic               w_head_vld;
    logic [DATA_W-1:0]  w_head_data;
    logic               w_head_err;
    logic [DATA_W-1:0]  w_nxt_buf_data [2];
    logic               w_nxt_buf_err  [2];
    logic [1:0]         w_nxt_cnt;
    logic               w_keep_inf;

    // Address decode: offset from base, range check and word index
    always_comb begin
        w_off_ext  = {1'b0, bus.addr} - {1'b0, BASE_ADDR};
        w_in_range = f_in_range(w_off_ext);
        // Low byte-lane bits are dropped; the range check guarantees the
        // remaining upper bits are zero for in-range accesses.
        w_idx      = IDX_W'(w_off_ext >> OFF_W);
    end

    // Response head selection, occupancy and grant
    always_comb begin
        w_head_vld = r_inf_vld || (r_cnt != 2'd0);
        if (r_cnt != 2'd0) begin
            w_head_data = r_buf_data[0];
            w_head_err  = r_buf_err[0];
        end else begin
            w_head_data = r_inf_data;
            w_head_err  = r_inf_err;
        end
        w_occ = r_cnt + {1'b0, r_inf_vld};
        w_pop = (!rst) && w_head_vld && bus.rready;
        // A slot is free, or the head leaves this cycle. req is deliberately
        // not part of this term.
        w_gnt = (!rst) && ((w_occ < 2'd2) || w_pop);
        w_acc = bus.req && w_gnt;
    end

    // Next response-buffer contents: pop the head, then append the in-flight
    // response behind whatever is left.
    always_comb begin
        w_nxt_buf_data = r_buf_data;
        w_nxt_buf_err  = r_buf_err;
        w_nxt_cnt      = r_cnt;
        w_keep_inf     = r_inf_vld;
        if (w_pop) begin
            if (r_cnt != 2'd0) begin
                w_nxt_buf_data[0] = r_buf_data[1];
                w_nxt_buf_err[0]  = r_buf_err[1];
                w_nxt_cnt         = r_cnt - 2'd1;
            end else begin
                // Head was the in-flight response itself
                w_keep_inf = 1'b0;
            end
        end else begin
            w_keep_inf = r_inf_vld;
        end
        if (w_keep_inf) begin
            case (w_nxt_cnt)
                2'd0: begin
                    w_nxt_buf_data[0] = r_inf_data;
                    w_nxt_buf_err[0]  = r_inf_err;
                    w_nxt_cnt         = 2'd1;
                end
                2'd1: begin
                    w_nxt_buf_data[1] = r_inf_data;
                    w_nxt_buf_err[1]  = r_inf_err;
                    w_nxt_cnt         = 2'd2;
                end
                default: begin
                    // Unreachable: grant keeps total occupancy at most 2
                    w_nxt_cnt = w_nxt_cnt;
                end
            endcase
        end else begin
            w_nxt_cnt = w_nxt_cnt;
        end
    end

    // Memory array write port with per-byte enables; never reset
    always_ff @(posedge clk) begin
        if (w_acc && w_in_range && bus.we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (bus.be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
                end
            end
        end
    end

    // Synchronous read into the in-flight data register; writes and
    // out-of-range requests return zero without touching the array
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inf_data <= '0;
        end else if (w_acc) begin
            if (w_in_range && !bus.we) begin
                r_inf_data <= r_mem[w_idx];
            end else begin
                r_inf_data <= '0;
            end
        end else begin
            r_inf_data <= r_inf_data;
        end
    end

    // In-flight flag and response buffer state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inf_vld     <= 1'b0;
            r_inf_err     <= 1'b0;
            r_cnt         <= 2'd0;
            r_buf_data[0] <= '0;
            r_buf_data[1] <= '0;
            r_buf_err[0]  <= 1'b0;
            r_buf_err[1]  <= 1'b0;
        end else begin
            r_inf_vld  <= w_acc;
            r_inf_err  <= w_acc && !w_in_range;
            r_cnt      <= w_nxt_cnt;
            r_buf_data <= w_nxt_buf_data;
            r_buf_err  <= w_nxt_buf_err;
        end
    end

    // Outputs are forced quiet while reset is held
    assign bus.gnt    = w_gnt;
    assign bus.rvalid = (!rst) && w_head_vld;
    assign bus.rdata  = rst ? '0 : w_head_data;
    assign bus.err    = (!rst) && w_head_vld && w_head_err;

endmodule

// File: tb/tb_ram_pipe.sv
// -----------------------------------------------------------------------------
// tb_ram_pipe
// Directed self-checking bench for ram_pipe. Window: BASE 0x1000, 256 words
// of 32 bits (bytes 0x1000..0x13FF). Inputs change 1 time unit after the
// rising edge; outputs are checked 2 units after it.
// -----------------------------------------------------------------------------
module tb_ram_pipe;
    localparam int          DW    = 32;
    localparam int          AW    = 32;
    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    ram_pipe_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    ram_pipe #(
        .DATA_W    (DW),
        .DEPTH     (DEPTH),
        .ADDR_W    (AW),
        .BASE_ADDR (BASE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Present one request and hold it until granted (bounded)
    task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d);
        int k;
        bus.req = 1'b1; bus.we = w; bus.addr = a; bus.be = b; bus.wdata = d;
        #1;
        k = 0;
        while (!bus.gnt && k < 16) begin
            @(posedge clk); #2; k++;
        end
        checks++;
        if (bus.gnt !== 1'b1) begin
            failures++;
            $display("FAIL issue_grant addr=%h got gnt=%b exp=1", a, bus.gnt);
        end
        @(posedge clk); #1;
        bus.req = 1'b0;
    endtask

    // Wait (bounded) for the next response with rready=1 and return it
    task automatic get_resp(output logic [31:0] d, output logic e);
        int k;
        bus.rready = 1'b1;
        #1;
        k = 0;
        while (!bus.rvalid && k < 16) begin
            @(posedge clk); #2; k++;
        end
        checks++;
        if (bus.rvalid !== 1'b1) begin
            failures++;
            $display("FAIL resp_timeout got rvalid=%b exp=1", bus.rvalid);
        end
        d = bus.rdata;
        e = bus.err;
        @(posedge clk); #1;
    endtask

    task automatic write_word(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd;
        logic        re;
        issue(1'b1, a, 4'hF, d);
        get_resp(rd, re);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = BASE; bus.be = 4'hF;
        bus.wdata = 32'h0; bus.rready = 1'b1;
        step; step;
        #1;
        checks++; if (bus.gnt !== 1'b0) begin failures++; $display("FAIL rst_gnt got=%b exp=0", bus.gnt); end
        checks++; if (bus.rvalid !== 1'b0) begin failures++; $display("FAIL rst_rvalid got=%b exp=0", bus.rvalid); end
        checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", bus.rdata); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", bus.err); end
        bus.req = 1'b0;
        rst = 1'b0;
        #1;
        checks++; if (bus.gnt !== 1'b1) begin failures++; $display("FAIL idle_gnt got=%b exp=1", bus.gnt); end
        checks++; if (bus.rvalid !== 1'b0) begin failures++; $display("FAIL idle_rvalid got=%b exp=0", bus.rvalid); end
        step;
    endtask

    task automatic test_write_read;
        issue(1'b1, BASE + 32'h10, 4'hF, 32'hDEAD_BEEF);
        #1;
        checks++; if (bus.rvalid !== 1'b1) begin failures++; $display("FAIL wr_rvalid got=%b exp=1", bus.rvalid); end
        checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL wr_rdata got=%h exp=0", bus.rdata); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL wr_err got=%b exp=0", bus.err); end
        step;
        issue(1'b0, BASE + 32'h10, 4'h0, 32'h0);
        #1;
        checks++; if (bus.rvalid !== 1'b1) begin failures++; $display("FAIL rd_rvalid got=%b exp=1", bus.rvalid); end
        checks++; if (bus.rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_rdata got=%h exp=deadbeef", bus.rdata); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL rd_err got=%b exp=0", bus.err); end
        step;
        #1;
        checks++; if (bus.rvalid !== 1'b0) begin failures++; $display("FAIL rd_drained got=%b exp=0", bus.rvalid); end
        step;
    endtask

    task automatic test_byte_enable;
        logic [31:0] d;
        logic        e;
        write_word(BASE + 32'h20, 32'hFFFF_FFFF);
        issue(1'b1, BASE + 32'h20, 4'b0101, 32'h1122_3344);
        get_resp(d, e);
        issue(1'b0, BASE + 32'h20, 4'h0, 32'h0);
        get_resp(d, e);
        checks++; if (d !== 32'hFF22_FF44) begin failures++; $display("FAIL be_merge got=%h exp=ff22ff44", d); end
        issue(1'b1, BASE + 32'h20, 4'h0, 32'h0000_0000);
        get_resp(d, e);
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL be0_err got=%b exp=0", e); end
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL be0_rdata got=%h exp=0", d); end
        // Unaligned address, and be ignored on a read
        issue(1'b0, BASE + 32'h23, 4'h1, 32'h0);
        get_resp(d, e);
        checks++; if (d !== 32'hFF22_FF44) begin failures++; $display("FAIL be0_unchanged got=%h exp=ff22ff44", d); end
    endtask

    task automatic test_out_of_range;
        logic [31:0] d;
        logic        e;
        write_word(BASE, 32'hA5A5_A5A5);
        write_word(BASE + 32'h3FC, 32'h0BAD_F00D);
        issue(1'b0, BASE + 32'h400, 4'hF, 32'h0);
        get_resp(d, e);
        checks++; if (e !== 1'b1) begin failures++; $display("FAIL oor_hi_err got=%b exp=1", e); end
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL oor_hi_rdata got=%h exp=0", d); end
        issue(1'b1, BASE + 32'h400, 4'hF, 32'h1234_5678);
        get_resp(d, e);
        checks++; if (e !== 1'b1) begin failures++; $display("FAIL oor_wr_err got=%b exp=1", e); end
        issue(1'b0, BASE - 32'h4, 4'hF, 32'h0);
        get_resp(d, e);
        checks++; if (e !== 1'b1) begin failures++; $display("FAIL oor_lo_err got=%b exp=1", e); end
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL oor_lo_rdata got=%h exp=0", d); end
        issue(1'b0, BASE + 32'h3FC, 4'hF, 32'h0);
        get_resp(d, e);
        checks++; if (e !== 1'b0 || d !== 32'h0BAD_F00D) begin failures++; $display("FAIL top_word got=%h/%b exp=0badf00d/0", d, e); end
        issue(1'b0, BASE, 4'hF, 32'h0);
        get_resp(d, e);
        checks++; if (d !== 32'hA5A5_A5A5) begin failures++; $display("FAIL oor_no_alias got=%h exp=a5a5a5a5", d); end
    endtask

    task automatic test_backpressure;
        logic [31:0] d;
        logic        e;
        int          g;
        for (int i = 1; i <= 4; i++) write_word(BASE + 32'(4*i), 32'h1111_0000 + 32'(i));
        bus.rready = 1'b0;
        bus.req = 1'b1; bus.we = 1'b0; bus.be = 4'hF;
        g = 0;
        for (int c = 0; c < 4; c++) begin
            bus.addr = BASE + 32'(4*(1+g));
            #1;
            checks++;
            if (bus.gnt !== (c < 2)) begin failures++; $display("FAIL bp_gnt%0d got=%b exp=%b", c, bus.gnt, (c < 2)); end
            if (bus.gnt) g++;
            step;
        end
        bus.req = 1'b0;
        #1;
        checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h1111_0001) begin failures++; $display("FAIL bp_head got=%b/%h exp=1/11110001", bus.rvalid, bus.rdata); end
        step;
        #1;
        checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h1111_0001) begin failures++; $display("FAIL bp_stable got=%b/%h exp=1/11110001", bus.rvalid, bus.rdata); end
        bus.rready = 1'b1;
        #1;
        checks++; if (bus.gnt !== 1'b1) begin failures++; $display("FAIL bp_gnt_pop got=%b exp=1", bus.gnt); end
        step;
        #1;
        checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h1111_0002) begin failures++; $display("FAIL bp_second got=%b/%h exp=1/11110002", bus.rvalid, bus.rdata); end
        step;
        #1;
        checks++; if (bus.rvalid !== 1'b0) begin failures++; $display("FAIL bp_drained got=%b exp=0", bus.rvalid); end
        step;
        issue(1'b0, BASE + 32'hC, 4'hF, 32'h0);
        get_resp(d, e);
        checks++; if (d !== 32'h1111_0003) begin failures++; $display("FAIL bp_third got=%h exp=11110003", d); end
        issue(1'b0, BASE + 32'h10, 4'hF, 32'h0);
        get_resp(d, e);
        checks++; if (d !== 32'h1111_0004) begin failures++; $display("FAIL bp_fourth got=%h exp=11110004", d); end
    endtask

    task automatic test_back_to_back;
        for (int i = 8; i < 16; i++) write_word(BASE + 32'(4*i), 32'hC0DE_0000 + 32'(i));
        bus.rready = 1'b1;
        bus.req = 1'b1; bus.we = 1'b0; bus.be = 4'hF;
        for (int i = 0; i < 8; i++) begin
            bus.addr = BASE + 32'(4*(8+i));
            #1;
            checks++; if (bus.gnt !== 1'b1) begin failures++; $display("FAIL b2b_gnt%0d got=%b exp=1", i, bus.gnt); end
            if (i > 0) begin
                checks++;
                if (bus.rvalid !== 1'b1 || bus.rdata !== 32'hC0DE_0000 + 32'(7+i)) begin
                    failures++; $display("FAIL b2b_resp%0d got=%b/%h exp=1/%h", i-1, bus.rvalid, bus.rdata, 32'hC0DE_0000 + 32'(7+i));
                end
            end
            step;
        end
        bus.req = 1'b0;
        #1;
        checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== 32'hC0DE_000F) begin failures++; $display("FAIL b2b_resp7 got=%b/%h exp=1/c0de000f", bus.rvalid, bus.rdata); end
        step;
        #1;
        checks++; if (bus.rvalid !== 1'b0) begin failures++; $display("FAIL b2b_drained got=%b exp=0", bus.rvalid); end
        // Write then read of the same word on consecutive cycles
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = BASE + 32'h50; bus.wdata = 32'h5555_AAAA;
        #1;
        checks++; if (bus.gnt !== 1'b1) begin failures++; $display("FAIL raw_wgnt got=%b exp=1", bus.gnt); end
        step;
        bus.we = 1'b0;
        #1;
        checks++; if (bus.gnt !== 1'b1 || bus.rvalid !== 1'b1 || bus.rdata !== 32'h0) begin failures++; $display("FAIL raw_wresp got=%b/%b/%h exp=1/1/0", bus.gnt, bus.rvalid, bus.rdata); end
        step;
        bus.req = 1'b0;
        #1;
        checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h5555_AAAA) begin failures++; $display("FAIL raw_read got=%b/%h exp=1/5555aaaa", bus.rvalid, bus.rdata); end
        step;
    endtask

    task automatic test_reset_flush;
        logic [31:0] d;
        logic        e;
        bus.rready = 1'b0;
        issue(1'b1, BASE + 32'h60, 4'hF, 32'h7777_8888);
        issue(1'b0, BASE + 32'h4, 4'hF, 32'h0);
        step;
        rst = 1'b1;
        #1;
        checks++; if (bus.rvalid !== 1'b0 || bus.gnt !== 1'b0) begin failures++; $display("FAIL flush_during got=%b/%b exp=0/0", bus.rvalid, bus.gnt); end
        step;
        rst = 1'b0;
        #1;
        checks++; if (bus.rvalid !== 1'b0) begin failures++; $display("FAIL flush_after got=%b exp=0", bus.rvalid); end
        bus.rready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step;
            #1;
            checks++; if (bus.rvalid !== 1'b0) begin failures++; $display("FAIL flush_stale%0d got=%b exp=0", i, bus.rvalid); end
        end
        step;
        issue(1'b0, BASE + 32'h60, 4'hF, 32'h0);
        get_resp(d, e);
        checks++; if (d !== 32'h7777_8888 || e !== 1'b0) begin failures++; $display("FAIL flush_kept_write got=%h/%b exp=77778888/0", d, e); end
    endtask

    initial begin
        rst = 1'b1;
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.be = '0;
        bus.wdata = '0; bus.rready = 1'b0;
        @(posedge clk); #1;
        test_reset;
        test_write_read;
        test_byte_enable;
        test_out_of_range;
        test_backpressure;
        test_back_to_back;
        test_reset_flush;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
